// File: rtl/ram_bist_master.sv
// Self-test master for the single-port 8x8 RAM: a write pass, then a read-back pass with compare.
// Define RAM_BIST_INV_EN to add a second write/read pass that uses the inverted pattern.
module ram_bist_master #(
    parameter int unsigned   DW   = 8,
    parameter int unsigned   AW   = 3,
    parameter logic [DW-1:0] SEED = 8'd30
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [AW-1:0] err_addr,
    output logic [AW+1:0] err_cnt,
    output logic          ram_cs,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);

`ifdef RAM_BIST_INV_EN
    localparam bit InvEn = 1'b1;
`else
    localparam bit InvEn = 1'b0;
`endif

    localparam logic [AW-1:0] LastAddr = {AW{1'b1}};

    typedef enum logic [2:0] {StIdle, StWrite, StRead, StDrain, StDone} state_e;

    state_e          state_q;
    logic [AW-1:0]   cnt_q;
    logic            phase_q;
    logic            err_seen_q;
    logic            pipe_vld_q;
    logic [AW-1:0]   pipe_addr_q;
    logic            pipe_inv_q;
    logic [DW-1:0]   exp_data;
    logic            mismatch;
    logic [AW+1:0]   err_cnt_nxt;

    function automatic logic [DW-1:0] pattern(input logic [AW-1:0] a, input logic inv);
        logic [DW-1:0] p;
        p = SEED + DW'(a);
        return inv ? ~p : p;
    endfunction

    assign ram_addr = cnt_q;

    // Case equality so that X/Z read data is counted as a failure in simulation.
    always_comb begin
        exp_data    = pattern(pipe_addr_q, pipe_inv_q);
        mismatch    = pipe_vld_q && (ram_dout !== exp_data);
        err_cnt_nxt = mismatch ? err_cnt + (AW+2)'(1) : err_cnt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            phase_q     <= 1'b0;
            err_seen_q  <= 1'b0;
            pipe_vld_q  <= 1'b0;
            pipe_addr_q <= '0;
            pipe_inv_q  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            err_addr    <= '0;
            err_cnt     <= '0;
            ram_cs      <= 1'b0;
            ram_we      <= 1'b0;
            ram_din     <= '0;
        end else begin
            done       <= 1'b0;
            pipe_vld_q <= 1'b0;
            if (mismatch) begin
                err_cnt <= err_cnt_nxt;
                if (!err_seen_q) begin
                    err_seen_q <= 1'b1;
                    err_addr   <= pipe_addr_q;
                end
            end
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q    <= StWrite;
                        busy       <= 1'b1;
                        pass       <= 1'b0;
                        err_cnt    <= '0;
                        err_addr   <= '0;
                        err_seen_q <= 1'b0;
                        cnt_q      <= '0;
                        phase_q    <= 1'b0;
                        ram_cs     <= 1'b1;
                        ram_we     <= 1'b1;
                        ram_din    <= pattern('0, 1'b0);
                    end
                end
                StWrite: begin
                    if (cnt_q == LastAddr) begin
                        state_q <= StRead;
                        cnt_q   <= '0;
                        ram_we  <= 1'b0;
                        ram_din <= '0;
                    end else begin
                        cnt_q   <= cnt_q + AW'(1);
                        ram_din <= pattern(cnt_q + AW'(1), phase_q);
                    end
                end
                StRead: begin
                    // Read data returns next cycle; remember which word it should be.
                    pipe_vld_q  <= 1'b1;
                    pipe_addr_q <= cnt_q;
                    pipe_inv_q  <= phase_q;
                    if (cnt_q == LastAddr) begin
                        cnt_q <= '0;
                        if (InvEn && !phase_q) begin
                            state_q <= StWrite;
                            phase_q <= 1'b1;
                            ram_we  <= 1'b1;
                            ram_din <= pattern('0, 1'b1);
                        end else begin
                            state_q <= StDrain;
                            ram_cs  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + AW'(1);
                    end
                end
                StDrain: begin
                    state_q <= StDone;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    pass    <= (err_cnt_nxt == '0);
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_bist_master.sv
// Bench for ram_bist_master: two DUTs (SEED 30 and 0xFC), each with a behavioural RAM that can
// inject read faults; table-driven result checks plus a start-while-busy / mid-run reset sequence.
module tb_ram_bist_master;

`ifdef RAM_BIST_INV_EN
    localparam bit InvEn = 1'b1;
`else
    localparam bit InvEn = 1'b0;
`endif
    // Rising edges from the start-sampling edge E0 to the edge after which done is high.
    localparam int LatExp = InvEn ? 33 : 17;

    logic       clk;
    logic       rst_n;
    logic       start_a, start_b;
    logic       busy_a, busy_b, done_a, done_b, pass_a, pass_b;
    logic [2:0] err_addr_a, err_addr_b;
    logic [4:0] err_cnt_a, err_cnt_b;
    logic       cs_a, cs_b, we_a, we_b;
    logic [2:0] addr_a, addr_b;
    logic [7:0] din_a, din_b, dout_a, dout_b;
    logic [7:0] mem_a [8];
    logic [7:0] mem_b [8];

    int         fault_mode;
    int         sel;
    int         n_tests;
    int         n_fail;

    logic       s_busy, s_done, s_pass;
    logic [2:0] s_err_addr;
    logic [4:0] s_err_cnt;

    ram_bist_master #(.DW(8), .AW(3), .SEED(8'd30)) u_dut_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start_a),
        .busy     (busy_a),
        .done     (done_a),
        .pass     (pass_a),
        .err_addr (err_addr_a),
        .err_cnt  (err_cnt_a),
        .ram_cs   (cs_a),
        .ram_we   (we_a),
        .ram_addr (addr_a),
        .ram_din  (din_a),
        .ram_dout (dout_a)
    );

    ram_bist_master #(.DW(8), .AW(3), .SEED(8'hFC)) u_dut_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start_b),
        .busy     (busy_b),
        .done     (done_b),
        .pass     (pass_b),
        .err_addr (err_addr_b),
        .err_cnt  (err_cnt_b),
        .ram_cs   (cs_b),
        .ram_we   (we_b),
        .ram_addr (addr_b),
        .ram_din  (din_b),
        .ram_dout (dout_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 1: address 3 bit 0 stuck at 0; 2: bit 7 stuck at 1 everywhere.
    function automatic logic [7:0] faulty(input logic [7:0] d, input logic [2:0] a);
        case (fault_mode)
            1:       return (a == 3'd3) ? (d & 8'hFE) : d;
            2:       return d | 8'h80;
            default: return d;
        endcase
    endfunction

    always @(posedge clk) begin
        if (cs_a && we_a) mem_a[addr_a] <= din_a;
        if (cs_a && !we_a) dout_a <= faulty(mem_a[addr_a], addr_a);
        if (cs_b && we_b) mem_b[addr_b] <= din_b;
        if (cs_b && !we_b) dout_b <= faulty(mem_b[addr_b], addr_b);
    end

    always_comb begin
        s_busy     = (sel == 1) ? busy_b : busy_a;
        s_done     = (sel == 1) ? done_b : done_a;
        s_pass     = (sel == 1) ? pass_b : pass_a;
        s_err_addr = (sel == 1) ? err_addr_b : err_addr_a;
        s_err_cnt  = (sel == 1) ? err_cnt_b : err_cnt_a;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Pulse start on the selected DUT and count edges until done; -1 if it never comes.
    task automatic run_bist(output int lat);
        lat = -1;
        @(negedge clk);
        if (sel == 1) start_b = 1'b1;
        else start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        start_b = 1'b0;
        check("busy_after_start", 32'(s_busy), 32'd1);
        for (int k = 1; k <= 80; k++) begin
            @(posedge clk);
            #1;
            if (s_done) begin
                lat = k;
                break;
            end
        end
    endtask

    typedef struct {
        int         sel;
        int         fault;
        logic       exp_pass;
        int         exp_addr;
        int         exp_cnt;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int         lat;
        logic [7:0] base;

        n_tests    = 0;
        n_fail     = 0;
        sel        = 0;
        fault_mode = 0;
        start_a    = 1'b0;
        start_b    = 1'b0;
        rst_n      = 1'b0;

        vecs[0] = '{0, 0, 1'b1, 0, 0};
        vecs[1] = '{0, 1, 1'b0, 3, 1};
        vecs[2] = '{0, 2, 1'b0, 0, 8};
        vecs[3] = '{0, 0, 1'b1, 0, 0};
        vecs[4] = '{1, 0, 1'b1, 0, 0};
        vecs[5] = '{1, 2, 1'b0, 4, InvEn ? 8 : 4};
        vecs[6] = '{1, 1, 1'b0, 3, 1};

        #2;
        check("reset_outputs_a",
              32'({busy_a, done_a, pass_a, err_addr_a, err_cnt_a, cs_a, we_a, addr_a, din_a}), 32'd0);
        check("reset_outputs_b",
              32'({busy_b, done_b, pass_b, err_addr_b, err_cnt_b, cs_b, we_b, addr_b, din_b}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            sel        = vecs[i].sel;
            fault_mode = vecs[i].fault;
            run_bist(lat);
            check($sformatf("v%0d_done_latency", i), 32'(lat), 32'(LatExp));
            check($sformatf("v%0d_busy_at_done", i), 32'(s_busy), 32'd0);
            check($sformatf("v%0d_pass", i), 32'(s_pass), 32'(vecs[i].exp_pass));
            check($sformatf("v%0d_err_addr", i), 32'(s_err_addr), 32'(vecs[i].exp_addr));
            check($sformatf("v%0d_err_cnt", i), 32'(s_err_cnt), 32'(vecs[i].exp_cnt));
            repeat (3) @(posedge clk);
            #1;
            check($sformatf("v%0d_result_hold", i), 32'({s_done, s_pass, s_err_addr, s_err_cnt}),
                  32'({1'b0, vecs[i].exp_pass, 3'(vecs[i].exp_addr), 5'(vecs[i].exp_cnt)}));
            if (i == 0) begin
                for (int a = 0; a < 8; a++) begin
                    base = 8'd30 + 8'(a);
                    check($sformatf("mem_a[%0d]", a), 32'(mem_a[a]), 32'(InvEn ? ~base : base));
                end
            end
            if (i == 4) begin
                for (int a = 0; a < 8; a++) begin
                    base = 8'hFC + 8'(a);
                    check($sformatf("mem_b[%0d]", a), 32'(mem_b[a]), 32'(InvEn ? ~base : base));
                end
            end
        end

        // Start at E0, stray start in E5, asynchronous reset just after E11 (mid READ).
        sel        = 0;
        fault_mode = 2;
        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("read_phase_we", 32'({cs_a, we_a, busy_a}), 32'({1'b1, 1'b0, 1'b1}));
        check("read_phase_addr", 32'(addr_a), 32'd3);
        check("err_cnt_before_reset", 32'(err_cnt_a), 32'd2);
        rst_n = 1'b0;
        #1;
        check("reset_cs_async", 32'(cs_a), 32'd0);
        check("reset_busy_async", 32'(busy_a), 32'd0);
        check("reset_err_cnt", 32'(err_cnt_a), 32'd0);
        @(negedge clk);
        rst_n      = 1'b1;
        fault_mode = 0;
        run_bist(lat);
        check("after_reset_latency", 32'(lat), 32'(LatExp));
        check("after_reset_pass", 32'({s_pass, s_err_cnt}), 32'({1'b1, 5'd0}));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
